instr_fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the single-cycle datapath. It generates sequential word addresses into the synchronous instruction memory and captures the returned words with their PCs. It buffers them in a 2-entry queue and presents them to the datapath over a valid/ready handshake. Branch/jump redirects flush all fetched-but-unconsumed work and restart fetch at the new target; a misaligned target raises a fetch fault.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input and the
// valid/ready instruction stream toward the datapath.
interface instr_fetch_unit_if #(
  parameter int IMEM_AW = 5
);
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               inst_valid;
  logic               inst_ready;
  logic [31:0]        inst_data;
  logic [31:0]        inst_pc;
  logic               inst_fault;

  // The fetch unit itself.
  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc, inst_fault,
    input  imem_data, redirect_valid, redirect_pc, inst_ready
  );

  // Instruction memory plus datapath side.
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, inst_fault,
    output imem_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch with a 1-cycle synchronous memory, a 2-entry
// delivery queue, credit-based issue and redirect/misaligned-fault handling.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 5
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {RUN, FAULT, HALT} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic [31:0] fault_pc;
  logic        inflight;
  logic [31:0] fifo_data [2];
  logic [31:0] fifo_pc   [2];
  logic        head;
  logic [1:0]  count;

  logic        pop;
  logic        fifo_pop;
  logic        push;
  logic        issue;
  logic        tail;
  logic [1:0]  occ;

  assign pop      = bus.inst_valid & bus.inst_ready;
  assign fifo_pop = pop && (state == RUN);
  assign push     = inflight && !bus.redirect_valid && !rst;
  assign tail     = head ^ count[0];
  assign occ      = count + {1'b0, inflight};

  // A pop in this cycle frees one credit, so issue may run one slot ahead.
  assign issue = (state == RUN) && !rst && !bus.redirect_valid &&
                 ((occ < 2'd2) || (fifo_pop && (occ < 2'd3)));

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc[IMEM_AW+1:2];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    bus.inst_valid = 1'b0;
    bus.inst_fault = 1'b0;
    bus.inst_data  = 32'h0;
    bus.inst_pc    = 32'h0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (count != 2'd0) begin
            bus.inst_valid = 1'b1;
            bus.inst_data  = fifo_data[head];
            bus.inst_pc    = fifo_pc[head];
          end
        end
        FAULT: begin
          bus.inst_valid = 1'b1;
          bus.inst_fault = 1'b1;
          bus.inst_pc    = fault_pc;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      fault_pc    <= 32'h0;
      head        <= 1'b0;
      count       <= 2'd0;
    end else if (bus.redirect_valid) begin
      // Redirect flushes everything, including a head offered this cycle.
      count    <= 2'd0;
      head     <= 1'b0;
      inflight <= 1'b0;
      if (bus.redirect_pc[1:0] == 2'b00) begin
        fetch_pc <= bus.redirect_pc;
        state    <= RUN;
      end else begin
        fault_pc <= bus.redirect_pc;
        state    <= FAULT;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      if (fifo_pop) head <= ~head;
      count <= count + {1'b0, push} - {1'b0, fifo_pop};
      if ((state == FAULT) && pop) state <= HALT;
    end
  end

  // NOTE: queue storage is not reset; count alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[tail] <= bus.imem_data;
      fifo_pc[tail]   <= inflight_pc;
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !fifo_pop && (count == 2'd2)));

endmodule
